// File: rtl/cdbus_line_pkg.sv
// Shared constants for the cdbus line conditioner: synchronizer depth,
// counter widths and the level the line rests at while idle or in reset.
package cdbus_line_pkg;

   localparam int   SYNC_STAGES = 2;
   localparam int   DIV_W       = 16;
   localparam int   BITCNT_W    = 8;
   localparam logic LINE_IDLE   = 1'b1;

   // The idle bit counter holds at all-ones rather than wrapping back below the threshold.
   function automatic logic [BITCNT_W-1:0] sat_inc(input logic [BITCNT_W-1:0] v);
      return (v == '1) ? v : v + BITCNT_W'(1);
   endfunction

endpackage

// File: rtl/cdbus_sync2.sv
// Two-flop synchronizer for the raw bus level; resets to the idle (high) level
// so that a reset never manufactures a falling edge downstream.
module cdbus_sync2
   import cdbus_line_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{LINE_IDLE}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdbus_line_cond.sv
// cdbus line conditioner: synchronize and deglitch the bus level, qualify bus idle,
// and (with CDBUS_LINE_COLL_EN defined) flag a driven-1 / read-0 collision.
module cdbus_line_cond
   import cdbus_line_pkg::*;
#(
   parameter int FILTER_LEN = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                bus_rx,
   input  logic                tx,
   input  logic                tx_en,
   input  logic [DIV_W-1:0]    div,
   input  logic [BITCNT_W-1:0] idle_bits,
   output logic                rx_f,
   output logic                rx_fall,
   output logic                bus_idle,
   output logic                collision
);

   logic                s_rx;
   logic [3:0]          filt_cnt_q, filt_cnt_d;
   logic                rx_f_q, rx_f_d;
   logic                rx_f_dly_q;
   logic                rx_fall_q;
   logic [DIV_W-1:0]    clk_cnt_q, clk_cnt_d;
   logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                bus_idle_q, bus_idle_d;

   cdbus_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (bus_rx),
      .q_o   (s_rx)
   );

   // Any sample agreeing with rx_f clears the run, so only an unbroken run flips it.
   always_comb begin
      filt_cnt_d = '0;
      rx_f_d     = rx_f_q;
      if (s_rx != rx_f_q) begin
         if (filt_cnt_q == 4'(FILTER_LEN - 1)) begin
            rx_f_d = s_rx;
         end else begin
            filt_cnt_d = filt_cnt_q + 4'd1;
         end
      end
   end

   always_comb begin
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      if (rx_f_q) begin
         if (clk_cnt_q == div) begin
            bit_cnt_d = sat_inc(bit_cnt_q);
         end else begin
            clk_cnt_d = clk_cnt_q + DIV_W'(1);
            bit_cnt_d = bit_cnt_q;
         end
      end
   end

   assign bus_idle_d = rx_f_q & (bit_cnt_q >= idle_bits);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_cnt_q <= '0;
         rx_f_q     <= LINE_IDLE;
         rx_f_dly_q <= LINE_IDLE;
         rx_fall_q  <= 1'b0;
         clk_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         bus_idle_q <= 1'b0;
      end else begin
         filt_cnt_q <= filt_cnt_d;
         rx_f_q     <= rx_f_d;
         rx_f_dly_q <= rx_f_q;
         rx_fall_q  <= rx_f_dly_q & ~rx_f_q;
         clk_cnt_q  <= clk_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         bus_idle_q <= bus_idle_d;
      end
   end

   assign rx_f     = rx_f_q;
   assign rx_fall  = rx_fall_q;
   assign bus_idle = bus_idle_q;

`ifdef CDBUS_LINE_COLL_EN
   // tx/tx_en see the same synchronizer + filter delay as the echoed line level.
   localparam int DLY_LEN = SYNC_STAGES + FILTER_LEN;

   logic [DLY_LEN-1:0] tx_dly_q;
   logic [DLY_LEN-1:0] en_dly_q;
   logic               coll_cond;
   logic               coll_cond_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_dly_q    <= '0;
         en_dly_q    <= '0;
         coll_cond_q <= 1'b0;
      end else begin
         tx_dly_q    <= {tx_dly_q[DLY_LEN-2:0], tx};
         en_dly_q    <= {en_dly_q[DLY_LEN-2:0], tx_en};
         coll_cond_q <= coll_cond;
      end
   end

   assign coll_cond = tx_dly_q[DLY_LEN-1] & en_dly_q[DLY_LEN-1] & ~rx_f_q;
   assign collision = coll_cond & ~coll_cond_q;
`else
   logic unused_tx;
   assign unused_tx = tx ^ tx_en;
   assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_cdbus_line_cond.sv
// Self-checking bench for cdbus_line_cond: directed scenarios plus randomized
// traffic compared every cycle against a history-based reference model.
module tb_cdbus_line_cond;

   localparam int FL = 3;
`ifdef CDBUS_LINE_COLL_EN
   localparam bit COLL_EN = 1'b1;
`else
   localparam bit COLL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        bus_rx;
   logic        tx;
   logic        tx_en;
   logic [15:0] div;
   logic [7:0]  idle_bits;
   logic        rx_f;
   logic        rx_fall;
   logic        bus_idle;
   logic        collision;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cdbus_line_cond #(.FILTER_LEN(FL)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus_rx    (bus_rx),
      .tx        (tx),
      .tx_en     (tx_en),
      .div       (div),
      .idle_bits (idle_bits),
      .rx_f      (rx_f),
      .rx_fall   (rx_fall),
      .bus_idle  (bus_idle),
      .collision (collision)
   );

   // Reference model: per-edge histories since the last reset release.
   bit   bus_h[$];
   bit   txp_h[$];
   bit   rxf_h[$];
   int   ticks_h[$];
   bit   cond_h[$];
   logic [3:0] exp_out;   // {rx_f, rx_fall, bus_idle, collision}

   function automatic bit samp(int j);
      // level the filter sees at edge j: the line two edges earlier, idle before that
      if (j < 2) return 1'b1;
      return bus_h[j-2];
   endfunction

   function automatic bit rxf_at(int j);
      if (j < 0) return 1'b1;
      return rxf_h[j];
   endfunction

   task automatic model_edge();
      int i, tp, bits;
      bit prev, prev2, flip, nr, idle, cond, cprev, coll;
      bus_h.push_back(bus_rx);
      txp_h.push_back(tx & tx_en);
      i     = bus_h.size() - 1;
      prev  = rxf_at(i - 1);
      prev2 = rxf_at(i - 2);
      flip  = (i - FL + 1 >= 0);
      for (int j = i - FL + 1; j <= i; j++) begin
         if (j >= 0 && samp(j) == prev) flip = 1'b0;
      end
      nr   = flip ? ~prev : prev;
      tp   = (i > 0) ? ticks_h[i-1] : 0;
      bits = tp / (int'(div) + 1);
      if (bits > 255) bits = 255;
      idle = prev && (bits >= int'(idle_bits));
      cond = ((i >= FL + 1) ? txp_h[i-FL-1] : 1'b0) && !nr;
      cprev = (i > 0) ? cond_h[i-1] : 1'b0;
      coll = COLL_EN && cond && !cprev;
      rxf_h.push_back(nr);
      ticks_h.push_back(prev ? tp + 1 : 0);
      cond_h.push_back(cond);
      exp_out = {nr, prev2 & ~prev, idle, coll};
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic release_reset();
      bus_h.delete(); txp_h.delete(); rxf_h.delete(); ticks_h.delete(); cond_h.delete();
      reset = 1'b0;
   endtask

   task automatic hold_reset(int n);
      reset = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus_rx = 1'b0; tx = 1'b1; tx_en = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_outputs n=%0d got=%b exp=1000", n, {rx_f, rx_fall, bus_idle, collision});
         end
      end
      bus_rx = 1'b1; tx = 1'b0; tx_en = 1'b0;
      release_reset();
      $display("test_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_filter_latency();
      int fall_at = -1, pulse_at = -1, pulses = 0;
      bus_rx = 1'b1;
      for (int n = 0; n < 12; n++) begin
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL latency_settle n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
      end
      bus_rx = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL latency_model n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
         if (!rx_f && fall_at < 0) fall_at = n;
         if (rx_fall) begin pulses++; if (pulse_at < 0) pulse_at = n; end
      end
      checks++;
      if (fall_at != FL + 2) begin
         errors++; $display("FAIL latency_edge got=%0d exp=%0d", fall_at, FL + 2);
      end
      checks++;
      if (pulses != 1 || pulse_at != FL + 3) begin
         errors++; $display("FAIL rx_fall_pulse got=%0d pulses at %0d exp=1 at %0d", pulses, pulse_at, FL + 3);
      end
      $display("test_filter_latency done: rx_f fell after %0d clocks, checks=%0d errors=%0d", fall_at, checks, errors);
   endtask

   task automatic test_glitch();
      int lows = 0, falls = 0;
      bus_rx = 1'b1;
      for (int n = 0; n < 12; n++) begin
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL glitch_settle n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
      end
      for (int n = 0; n < 14; n++) begin
         bus_rx = (n == 0 || n == 1) ? 1'b0 : 1'b1;
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL glitch_model n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
         if (!rx_f) lows++;
         if (rx_fall) falls++;
      end
      checks++;
      if (lows != 0 || falls != 0) begin
         errors++; $display("FAIL glitch_reject got=%0d low cycles, %0d falls exp=0,0", lows, falls);
      end
      $display("test_glitch done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_idle();
      int rise_at = -1, idle_at = -1, fall_at = -1, drop_at = -1;
      bus_rx = 1'b0;
      for (int n = 0; n < 8; n++) begin
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL idle_low n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
      end
      div = 16'd9; idle_bits = 8'd10; bus_rx = 1'b1;
      for (int n = 1; n <= 150; n++) begin
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL idle_model n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
         if (rx_f && rise_at < 0) rise_at = n;
         if (bus_idle && idle_at < 0) idle_at = n;
      end
      checks++;
      if (rise_at < 0 || idle_at < 0 || idle_at - rise_at != 101) begin
         errors++; $display("FAIL idle_assert got rise=%0d idle=%0d exp gap=101", rise_at, idle_at);
      end
      bus_rx = 1'b0;
      for (int n = 1; n <= 15; n++) begin
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL idle_drop_model n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
         if (!rx_f && fall_at < 0) fall_at = n;
         if (!bus_idle && drop_at < 0) drop_at = n;
      end
      checks++;
      if (fall_at < 0 || drop_at != fall_at + 1) begin
         errors++; $display("FAIL idle_drop got fall=%0d drop=%0d exp drop=fall+1", fall_at, drop_at);
      end
      $display("test_idle done: idle after %0d clocks, checks=%0d errors=%0d", idle_at - rise_at, checks, errors);
   endtask

   task automatic test_collision();
      int pulses = 0, first = -1;
      bus_rx = 1'b0; tx = 1'b0; tx_en = 1'b0;
      for (int n = 0; n < 8; n++) begin
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL coll_settle n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
      end
      tx = 1'b1; tx_en = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL coll_model n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
         if (collision) begin pulses++; if (first < 0) first = n; end
      end
      tx = 1'b0; tx_en = 1'b0;
      checks++;
      if (COLL_EN ? (pulses != 1 || first != FL + 2) : (pulses != 0)) begin
         errors++; $display("FAIL coll_pulse got=%0d pulses first=%0d exp=%0d at %0d", pulses, first, COLL_EN ? 1 : 0, FL + 2);
      end
      $display("test_collision done: %0d pulses, checks=%0d errors=%0d", pulses, checks, errors);
   endtask

   task automatic test_reset_mid_idle();
      bit found = 1'b0;
      int idle_at = -1;
      bus_rx = 1'b1;
      for (int n = 0; n < 150 && !found; n++) begin
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL midrst_pre n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
         if (ticks_h[ticks_h.size()-1] == 75) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL midrst_reach got=not reached exp=bit count 7");
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({rx_f, rx_fall, bus_idle, collision} !== 4'b1000) begin
         errors++; $display("FAIL midrst_async got=%b exp=1000", {rx_f, rx_fall, bus_idle, collision});
      end
      @(posedge clk); #1;
      release_reset();
      for (int n = 1; n <= 150; n++) begin
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL midrst_post n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
         if (bus_idle && idle_at < 0) idle_at = n;
      end
      checks++;
      if (idle_at != 101) begin
         errors++; $display("FAIL midrst_requalify got=%0d exp=101", idle_at);
      end
      $display("test_reset_mid_idle done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_boundary();
      int hold = 0;
      logic prev_rxf;
      div = 16'd0; idle_bits = 8'd0;
      hold_reset(2);
      release_reset();
      prev_rxf = 1'b1;
      for (int n = 0; n < 200; n++) begin
         if (hold == 0) begin bus_rx = 1'($urandom_range(0, 1)); hold = $urandom_range(1, 8); end
         hold--;
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL boundary_model n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
         checks++;
         if (bus_idle !== prev_rxf) begin
            errors++; $display("FAIL boundary_track n=%0d got=%b exp=%b", n, bus_idle, prev_rxf);
         end
         prev_rxf = rx_f;
      end
      idle_bits = 8'd255;
      hold_reset(2);
      bus_rx = 1'b1;
      release_reset();
      for (int n = 0; n < 600; n++) begin
         tick(); checks++;
         if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
            errors++; $display("FAIL saturate_model n=%0d got=%b exp=%b", n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
         end
      end
      checks++;
      if (bus_idle !== 1'b1) begin
         errors++; $display("FAIL saturate_hold got=%b exp=1", bus_idle);
      end
      $display("test_boundary done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_random();
      int hold = 0;
      for (int r = 0; r < 4; r++) begin
         div = 16'($urandom_range(0, 4));
         idle_bits = 8'($urandom_range(0, 6));
         hold_reset(2);
         release_reset();
         for (int n = 0; n < 600; n++) begin
            if (hold == 0) begin bus_rx = 1'($urandom_range(0, 1)); hold = $urandom_range(1, 10); end
            hold--;
            tx = 1'($urandom_range(0, 1));
            tx_en = ($urandom_range(0, 3) != 0);
            tick(); checks++;
            if ({rx_f, rx_fall, bus_idle, collision} !== exp_out) begin
               errors++; $display("FAIL random r=%0d n=%0d got=%b exp=%b", r, n, {rx_f, rx_fall, bus_idle, collision}, exp_out);
            end
         end
         $display("test_random round %0d (div=%0d idle_bits=%0d) done: checks=%0d errors=%0d", r, div, idle_bits, checks, errors);
      end
      tx = 1'b0; tx_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; bus_rx = 1'b1; tx = 1'b0; tx_en = 1'b0;
      div = 16'd9; idle_bits = 8'd10;
      test_reset();
      test_filter_latency();
      test_glitch();
      test_idle();
      test_collision();
      test_reset_mid_idle();
      test_boundary();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cdbus_line_cond.md
CDBUS_LINE_COND -- requirements
Module: cdbus_line_cond

Interface
- REQ-001 The block SHALL have exactly one clock and one reset; the reset is asynchronous and active-high. Ports are named clk and reset.
- REQ-002 Parameter FILTER_LEN, default 3, SHALL set the number of consecutive equal samples (range 1..15) needed to change rx_f.
- REQ-003 clk  input  1  rising-edge clock for all state.
- REQ-004 reset  input  1  asynchronous active-high reset.
- REQ-005 bus_rx  input  1  raw, asynchronous line level from the transceiver.
- REQ-006 tx  input  1  transmit bit driven by the cdbus core.
- REQ-007 tx_en  input  1  transmit enable driven by the cdbus core.
- REQ-008 div  input  16  clocks per bit minus 1; quasi-static.
- REQ-009 idle_bits  input  8  number of high bit-times that qualify the bus as idle; quasi-static.
- REQ-010 rx_f  output  1  filtered line level, fed to the rx input of the cdbus core.
- REQ-011 rx_fall  output  1  one-cycle pulse on each falling edge of rx_f.
- REQ-012 bus_idle  output  1  high while the line has been idle for at least idle_bits bit-times.
- REQ-013 collision  output  1  one-cycle pulse when the core drives 1 but the line reads 0.

Function
- REQ-014 bus_rx SHALL pass through a 2-flop synchronizer; the synchronizer output is s_rx.
- REQ-015 rx_f SHALL change to the value of s_rx only after s_rx differs from rx_f on FILTER_LEN consecutive clocks.
- REQ-016 Any s_rx sample equal to rx_f SHALL reset the filter count to 0, so glitches shorter than FILTER_LEN cycles are rejected.
- REQ-017 Latency from a clean bus_rx edge to an rx_f edge SHALL be exactly 2+FILTER_LEN clocks.
- REQ-018 rx_fall SHALL be registered, asserting in the cycle after rx_f goes from 1 to 0.
- REQ-019 Bit-time counting:
  - A clock counter SHALL count 0..div; reaching div completes one bit-time and wraps to 0.
  - The counter SHALL restart at 0 whenever rx_f is 0.
  - A saturating 8-bit bit counter SHALL increment once per completed bit-time while rx_f is 1.
- REQ-020 bus_idle SHALL assert in the cycle after the bit counter reaches idle_bits.
- REQ-021 bus_idle SHALL deassert, and both counters SHALL clear, in the cycle after rx_f falls.
- REQ-022 When idle_bits is 0, bus_idle SHALL equal rx_f delayed by one clock.
- REQ-023 When div is 0, every clock SHALL count as one bit-time.
- REQ-024 Collision detection:
  - tx and tx_en SHALL be delayed by a 2+FILTER_LEN stage shift register so they align with rx_f.
  - collision SHALL pulse for one cycle when the delayed tx_en is 1, the delayed tx is 1, and rx_f is 0.
  - It SHALL re-pulse only after that condition has been false for at least one cycle.
- REQ-025 If bus_rx rises and falls in the same cycle as an idle threshold is reached, the falling edge SHALL take priority: bus_idle stays 0.

Reset
- REQ-026 While reset is 1, the outputs SHALL be: rx_f=1, rx_fall=0, bus_idle=0, collision=0.
- REQ-027 While reset is 1, internal state SHALL be: synchronizer flops=1, all counters=0, delay line=0.
- REQ-028 Reset asserted mid-frame SHALL take effect immediately, with no partial pulse afterwards.
- REQ-029 After reset release, idle SHALL be re-qualified from a count of 0.

Configuration
- REQ-030 With macro CDBUS_LINE_COLL_EN defined, the tx delay line and collision logic SHALL be built as in REQ-024.
- REQ-031 Without CDBUS_LINE_COLL_EN, collision SHALL be tied to 0, the delay line SHALL be omitted, and tx and tx_en SHALL be unused.

Structure
- REQ-032 Package cdbus_line_pkg SHALL hold:
  - SYNC_STAGES=2;
  - the counter widths, DIV_W=16 and BITCNT_W=8;
  - the reset level constant LINE_IDLE=1.
- REQ-033 The synchronizer SHALL be a separate sub-module, cdbus_sync2, with async active-high reset and reset value 1.

Verification
- REQ-034 Filter latency: with FILTER_LEN=3, drive a clean 1->0 step on bus_rx -> rx_f falls exactly 5 clocks later, and rx_fall pulses for 1 cycle on the next clock.
- REQ-035 Glitch rejection: drive a 2-cycle low glitch on bus_rx with FILTER_LEN=3 -> rx_f stays 1 and rx_fall stays 0.
- REQ-036 Idle assertion: set div=9 and idle_bits=10, then hold the line high -> bus_idle asserts 101 clocks after the rx_f rise and drops 1 clock after the next rx_f fall.
- REQ-037 Collision: with CDBUS_LINE_COLL_EN defined, set tx_en=1 and tx=1 while bus_rx=0 for 20 cycles -> collision is a single 1-cycle pulse, 5 clocks after the first overlap; without the macro, collision stays 0.
- REQ-038 Reset mid-idle-count: assert reset for 1 cycle at bit count 7 of 10 -> bus_idle=0, and it asserts 10 full bit-times after reset release.
- REQ-039 Boundary settings: with div=0 and idle_bits=0, bus_idle tracks rx_f with 1 clock delay.
